// File: rtl/raster_to_block_stream_if.sv
// Raster-in / block-out stream bundle for raster_to_block_stream.
// pixel_valid qualifies pixel_in and frame_start, data_valid qualifies data_out and the strobes; no ready, no backpressure.
interface raster_to_block_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] pixel_in;
    logic                  pixel_valid;
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  start_data;
    logic                  start_of_frame;
    logic                  end_of_frame;
    logic [31:0]           blocks_per_frame;
    logic                  overflow;

    modport master (
        output pixel_in, pixel_valid, frame_start,
        input  data_out, data_valid, start_data, start_of_frame, end_of_frame,
        input  blocks_per_frame, overflow
    );

    modport slave (
        input  pixel_in, pixel_valid, frame_start,
        output data_out, data_valid, start_data, start_of_frame, end_of_frame,
        output blocks_per_frame, overflow
    );
endinterface

// File: rtl/raster_to_block_stream.sv
// Reorders a raster pixel stream into BLOCK_W x BLOCK_H blocks through a ping-pong band buffer,
// emitting block/frame strobes for the downstream noise estimator.
module raster_to_block_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 8,
    parameter int FRAME_HEIGHT = 4,
    parameter int BLOCK_W      = 4,
    parameter int BLOCK_H      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    raster_to_block_stream_if.slave   bus,
    output logic                      dbg_rd_state
);
    localparam int NUM_BLK    = FRAME_WIDTH / BLOCK_W;
    localparam int NUM_BAND   = FRAME_HEIGHT / BLOCK_H;
    localparam int BANK_WORDS = BLOCK_H * FRAME_WIDTH;
    localparam int ADDR_W     = $clog2(2 * BANK_WORDS);
    localparam int COL_W      = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int LINE_W     = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam int BAND_W     = (NUM_BAND > 1) ? $clog2(NUM_BAND) : 1;
    localparam int BLK_W      = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam int BCOL_W     = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(FRAME_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(BLOCK_H - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BAND - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NUM_BLK - 1);
    localparam logic [BCOL_W-1:0] BCOL_LAST = BCOL_W'(BLOCK_W - 1);

    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [0:2*BANK_WORDS-1];
    logic [DATA_WIDTH-1:0] ram_q;

    logic              wr_active, wr_bank, overflow;
    logic [COL_W-1:0]  wr_col, w_col;
    logic [LINE_W-1:0] wr_line, w_line;
    logic [BAND_W-1:0] wr_band, w_band;
    logic [1:0]        wr_tog, rd_tog, bank_full, bank_first, bank_last;
    logic              wr_en, wr_blocked, wr_take;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    rd_state_t         rd_state;
    logic              rd_bank, rd_last, rd_done;
    logic [BLK_W-1:0]  rd_blk;
    logic [LINE_W-1:0] rd_row;
    logic [BCOL_W-1:0] rd_bcol;
    logic              valid_q, start_q, sof_q, eof_q;

    // A bank is full while its write-completion toggle differs from its read-completion toggle.
    assign bank_full = wr_tog ^ rd_tog;

    always_comb begin
        w_col      = bus.frame_start ? '0 : wr_col;
        w_line     = bus.frame_start ? '0 : wr_line;
        w_band     = bus.frame_start ? '0 : wr_band;
        wr_en      = bus.pixel_valid && (bus.frame_start || wr_active);
        rd_last    = (rd_blk == BLK_LAST) && (rd_row == LINE_LAST) && (rd_bcol == BCOL_LAST);
        rd_done    = (rd_state == RD_STREAM) && rd_last;
        // The bank whose last word is read this cycle is free for the write landing on the same edge.
        wr_blocked = bank_full[wr_bank] && !(rd_done && (rd_bank == wr_bank));
        wr_take    = wr_en && !wr_blocked;
        wr_addr    = ADDR_W'(BANK_WORDS) * ADDR_W'(wr_bank) + ADDR_W'(FRAME_WIDTH) * ADDR_W'(w_line)
                   + ADDR_W'(w_col);
        rd_addr    = ADDR_W'(BANK_WORDS) * ADDR_W'(rd_bank) + ADDR_W'(FRAME_WIDTH) * ADDR_W'(rd_row)
                   + ADDR_W'(BLOCK_W) * ADDR_W'(rd_blk) + ADDR_W'(rd_bcol);
    end

    always_ff @(posedge clk) begin
        if (wr_take) mem[wr_addr] <= bus.pixel_in;
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_active  <= 1'b0;
            wr_bank    <= 1'b0;
            wr_col     <= '0;
            wr_line    <= '0;
            wr_band    <= '0;
            wr_tog     <= '0;
            bank_first <= '0;
            bank_last  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en && wr_blocked) overflow <= 1'b1;
            if (wr_take) begin
                wr_active <= 1'b1;
                wr_line   <= w_line;
                wr_band   <= w_band;
                if (w_col == COL_LAST) begin
                    wr_col <= '0;
                    if (w_line == LINE_LAST) begin
                        wr_line             <= '0;
                        wr_bank             <= ~wr_bank;
                        wr_tog[wr_bank]     <= ~wr_tog[wr_bank];
                        bank_first[wr_bank] <= (w_band == '0);
                        bank_last[wr_bank]  <= (w_band == BAND_LAST);
                        if (w_band == BAND_LAST) begin
                            wr_band   <= '0;
                            wr_active <= 1'b0;
                        end else begin
                            wr_band <= w_band + 1'b1;
                        end
                    end else begin
                        wr_line <= w_line + 1'b1;
                    end
                end else begin
                    wr_col <= w_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_bank  <= 1'b0;
            rd_blk   <= '0;
            rd_row   <= '0;
            rd_bcol  <= '0;
            rd_tog   <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            valid_q <= (rd_state == RD_STREAM);
            start_q <= (rd_state == RD_STREAM) && (rd_row == '0) && (rd_bcol == '0);
            sof_q   <= (rd_state == RD_STREAM) && (rd_row == '0) && (rd_bcol == '0)
                       && (rd_blk == '0) && bank_first[rd_bank];
            eof_q   <= rd_done && bank_last[rd_bank];
            case (rd_state)
                RD_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_state <= RD_STREAM;
                        rd_blk   <= '0;
                        rd_row   <= '0;
                        rd_bcol  <= '0;
                    end
                end
                RD_STREAM: begin
                    if (rd_last) begin
                        rd_tog[rd_bank] <= ~rd_tog[rd_bank];
                        rd_bank         <= ~rd_bank;
                        rd_blk          <= '0;
                        rd_row          <= '0;
                        rd_bcol         <= '0;
                        // Chain straight into the other bank when it is ready so continuous input never overruns.
                        if (!bank_full[~rd_bank]) rd_state <= RD_IDLE;
                    end else if (rd_bcol == BCOL_LAST) begin
                        rd_bcol <= '0;
                        if (rd_row == LINE_LAST) begin
                            rd_row <= '0;
                            rd_blk <= rd_blk + 1'b1;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end else begin
                        rd_bcol <= rd_bcol + 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign bus.data_out         = valid_q ? ram_q : '0;
    assign bus.data_valid       = valid_q;
    assign bus.start_data       = start_q;
    assign bus.start_of_frame   = sof_q;
    assign bus.end_of_frame     = eof_q;
    assign bus.overflow         = overflow;
    assign bus.blocks_per_frame = 32'(NUM_BLK * NUM_BAND);
    assign dbg_rd_state         = (rd_state == RD_STREAM);
endmodule
